// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing
// Description : Raster timing generator. Produces pixel coordinates, blanking
//               flag, active-low hsync/vsync, pixel strobe and frame-start
//               pulse from one system clock with an integer pixel divider.
//               All outputs are registered from next-state counter values so
//               they describe the same (row, col) on every cycle.
//               Optional frame counter: define VGA_TIMING_FRAME_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing #(
  parameter int unsigned DIV      = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [31:0] row,
  output logic [31:0] col,
  output logic        hsync,
  output logic        vsync,
  output logic        vnotactive,
  output logic        pix_tick,
  output logic        frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  // Timing landmarks, all as 32-bit unsigned values for width-matched compares
  localparam logic [31:0] c_DIV_LAST = 32'(DIV - 1);
  localparam logic [31:0] c_H_ACTIVE = 32'(H_ACTIVE);
  localparam logic [31:0] c_H_LAST   = 32'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [31:0] c_HS_START = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] c_HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [31:0] c_V_ACTIVE = 32'(V_ACTIVE);
  localparam logic [31:0] c_V_LAST   = 32'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [31:0] c_VS_START = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] c_VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC - 1);
  // With DIV=1 every clock is a pixel clock, so the strobe resets high
  localparam logic        c_PIX_RST  = (DIV == 1) ? 1'b1 : 1'b0;

  logic [31:0] div_cnt_q, div_cnt_d;
  logic [31:0] col_q, col_d;
  logic [31:0] row_q, row_d;
  logic        pix_tick_q, pix_tick_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        vnotactive_q, vnotactive_d;
  logic        frame_start_q, frame_start_d;
  logic        line_end, frame_end;

  // Next-state: divider, counters, and sync/blank decoded from next counters
  always_comb begin
    div_cnt_d = (div_cnt_q == c_DIV_LAST) ? 32'd0 : div_cnt_q + 32'd1;
    pix_tick_d = (div_cnt_d == c_DIV_LAST);

    // pix_tick_q is high exactly while div_cnt_q == DIV-1, i.e. this edge
    // is the one that advances the column
    line_end  = pix_tick_q && (col_q == c_H_LAST);
    frame_end = line_end && (row_q == c_V_LAST);

    col_d = col_q;
    row_d = row_q;
    if (pix_tick_q) begin
      col_d = line_end ? 32'd0 : col_q + 32'd1;
    end
    if (line_end) begin
      row_d = frame_end ? 32'd0 : row_q + 32'd1;
    end

    hsync_d       = !((col_d >= c_HS_START) && (col_d <= c_HS_END));
    vsync_d       = !((row_d >= c_VS_START) && (row_d <= c_VS_END));
    vnotactive_d  = (col_d >= c_H_ACTIVE) || (row_d >= c_V_ACTIVE);
    frame_start_d = frame_end;
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      div_cnt_q     <= 32'd0;
      col_q         <= 32'd0;
      row_q         <= 32'd0;
      pix_tick_q    <= c_PIX_RST;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      vnotactive_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      col_q         <= col_d;
      row_q         <= row_d;
      pix_tick_q    <= pix_tick_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      vnotactive_q  <= vnotactive_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign row         = row_q;
  assign col         = col_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign vnotactive  = vnotactive_q;
  assign pix_tick    = pix_tick_q;
  assign frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Frame counter advances on the same edge that raises frame_start
  always_comb begin
    frame_cnt_d = frame_end ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  // Frame counter register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      frame_cnt_q <= 16'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing
// Description : Self-checking bench for vga_timing. Full-size 640x480 timing
//               at DIV=1/2/3 for line-level checks, plus a reduced raster
//               (16x12 totals) for frame wrap, vsync and mid-frame reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing;

  logic CLK;
  logic RST;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Full-size instances
  logic [31:0] row1, col1, row2, col2, row3, col3;
  logic hs1, vs1, vna1, pt1, fs1;
  logic hs2, vs2, vna2, pt2, fs2;
  logic hs3, vs3, vna3, pt3, fs3;
  // Reduced instance: H 8/2/3/3 (total 16), V 6/2/2/2 (total 12)
  logic [31:0] rows, cols;
  logic hss, vss, vnas, pts, fss;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fc1, fc2, fc3, fcs;
`endif

  vga_timing #(.DIV(1)) u_d1 (
    .CLK(CLK), .RST(RST), .row(row1), .col(col1), .hsync(hs1), .vsync(vs1),
    .vnotactive(vna1), .pix_tick(pt1), .frame_start(fs1)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc1)
`endif
  );
  vga_timing #(.DIV(2)) u_d2 (
    .CLK(CLK), .RST(RST), .row(row2), .col(col2), .hsync(hs2), .vsync(vs2),
    .vnotactive(vna2), .pix_tick(pt2), .frame_start(fs2)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc2)
`endif
  );
  vga_timing #(.DIV(3)) u_d3 (
    .CLK(CLK), .RST(RST), .row(row3), .col(col3), .hsync(hs3), .vsync(vs3),
    .vnotactive(vna3), .pix_tick(pt3), .frame_start(fs3)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc3)
`endif
  );
  vga_timing #(.DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
               .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)) u_sm (
    .CLK(CLK), .RST(RST), .row(rows), .col(cols), .hsync(hss), .vsync(vss),
    .vnotactive(vnas), .pix_tick(pts), .frame_start(fss)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fcs)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;
  int fs_seen[$];
  int vs_low_cnt;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reset-state check for every instance: {row, col, hs, vs, vna, fs}
  task automatic chk_reset(input string tag);
    chk({tag, "_d1"}, {row1, col1, hs1, vs1, vna1, fs1, pt1}, {64'd0, 5'b11001});
    chk({tag, "_d2"}, {row2, col2, hs2, vs2, vna2, fs2, pt2}, {64'd0, 5'b11000});
    chk({tag, "_d3"}, {row3, col3, hs3, vs3, vna3, fs3, pt3}, {64'd0, 5'b11000});
    chk({tag, "_sm"}, {rows, cols, hss, vss, vnas, fss, pts}, {64'd0, 5'b11001});
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk({tag, "_fc"}, {fc1, fc2, fc3, fcs}, 64'd0);
`endif
  endtask

  // Checks the reduced raster against a reference derived from its timing,
  // for edges 0..ncyc after reset release
  task automatic run_small(input string tag, input int ncyc);
    logic [31:0] er, ec;
    logic ehs, evs, evna, efs;
    for (int n = 0; n <= ncyc; n++) begin
      if (n > 0) tick();
      ec   = 32'(n % 16);
      er   = 32'((n / 16) % 12);
      ehs  = !(ec >= 10 && ec <= 12);
      evs  = !(er >= 8 && er <= 9);
      evna = (ec >= 8) || (er >= 6);
      efs  = (n > 0) && (n % 192 == 0);
      chk($sformatf("%s_n%0d", tag, n), {rows, cols, hss, vss, vnas, fss},
          {er, ec, ehs, evs, evna, efs});
`ifdef VGA_TIMING_FRAME_CNT_EN
      chk($sformatf("%s_fc_n%0d", tag, n), {112'd0, fcs}, {112'd0, 16'(n / 192)});
`endif
      if (fss) fs_seen.push_back(n);
      if (!vss) vs_low_cnt++;
    end
  endtask

  typedef struct {
    int          cyc;
    logic [31:0] row1;
    logic [31:0] col1;
    logic        hs1;
    logic        vna1;
    logic [31:0] col2;
    logic [31:0] col3;
  } vec_t;

  vec_t vt[14];

  initial begin
    int n;
    // edges after release -> expected DIV=1 state, DIV=2 col, DIV=3 col
    vt[0]  = '{0,   0, 0,   1'b1, 1'b0, 0,   0};
    vt[1]  = '{1,   0, 1,   1'b1, 1'b0, 0,   0};
    vt[2]  = '{2,   0, 2,   1'b1, 1'b0, 1,   0};
    vt[3]  = '{3,   0, 3,   1'b1, 1'b0, 1,   1};
    vt[4]  = '{4,   0, 4,   1'b1, 1'b0, 2,   1};
    vt[5]  = '{639, 0, 639, 1'b1, 1'b0, 319, 213};
    vt[6]  = '{640, 0, 640, 1'b1, 1'b1, 320, 213};
    vt[7]  = '{655, 0, 655, 1'b1, 1'b1, 327, 218};
    vt[8]  = '{656, 0, 656, 1'b0, 1'b1, 328, 218};
    vt[9]  = '{751, 0, 751, 1'b0, 1'b1, 375, 250};
    vt[10] = '{752, 0, 752, 1'b1, 1'b1, 376, 250};
    vt[11] = '{799, 0, 799, 1'b1, 1'b1, 399, 266};
    vt[12] = '{800, 1, 0,   1'b1, 1'b0, 400, 266};
    vt[13] = '{801, 1, 1,   1'b1, 1'b0, 400, 267};

    // Reset held for 5 clocks
    RST = 1'b0;
    repeat (5) tick();
    chk_reset("reset");
    RST = 1'b1;
    n = 0;

    // Line-level vectors
    for (int i = 0; i < 14; i++) begin
      while (n < vt[i].cyc) begin
        tick();
        n++;
      end
      chk($sformatf("vec%0d_d1", i), {row1, col1, hs1, vs1, vna1},
          {vt[i].row1, vt[i].col1, vt[i].hs1, 1'b1, vt[i].vna1});
      chk($sformatf("vec%0d_d2d3", i), {col2, col3}, {vt[i].col2, vt[i].col3});
    end

    // DIV=3 hold and strobe alignment, DIV=2 strobe, DIV=1 constant strobe
    for (int k = 0; k < 9; k++) begin
      tick();
      n++;
      chk($sformatf("div3_n%0d", n), {col3, pt3}, {32'(n / 3), (n % 3 == 2)});
      chk($sformatf("pix_d2d1_n%0d", n), {pt2, pt1}, {(n % 2 == 1), 1'b1});
    end

    // Reduced raster: two full frames plus some
    RST = 1'b0;
    tick();
    RST = 1'b1;
    fs_seen.delete();
    vs_low_cnt = 0;
    run_small("frame", 400);
    if (fs_seen.size() >= 2)
      chk("frame_period", 128'(fs_seen[1] - fs_seen[0]), 128'd192);
    else
      chk("frame_start_count", 128'(fs_seen.size()), 128'd2);
    chk("vsync_low_cycles", 128'(vs_low_cnt), 128'd64);

    // Mid-frame asynchronous reset at row 5, col 5, between clock edges
    RST = 1'b0;
    tick();
    RST = 1'b1;
    run_small("pre_rst", 85);
    RST = 1'b0;
    #2;
    chk_reset("async_rst");
    tick();
    tick();
    RST = 1'b1;
    fs_seen.delete();
    vs_low_cnt = 0;
    run_small("post_rst", 193);
    chk("post_rst_fs_first", 128'(fs_seen.size() > 0 ? fs_seen[0] : -1), 128'd192);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_timing.md
# vga_timing

Raster timing generator feeding the pixel renderer. It produces the current pixel coordinates (`row`, `col`), the blanking flag (`vnotactive`) and the active-low VGA sync pulses from one system clock with an integer pixel-clock divider. It drives the coordinate/blank inputs of the display block and the `hsync`/`vsync` pins. All outputs are registered and mutually aligned, so the renderer's registered RGB lags them by exactly one clock.

## Interface
- `DIV`, 2, system clocks per pixel (≥1; 2 gives 25 MHz pixels from 50 MHz)
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch
- `H_SYNC`, 96, horizontal sync width
- `H_BP`, 48, horizontal back porch
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch
- `V_SYNC`, 2, vertical sync width
- `V_BP`, 33, vertical back porch
- `CLK`  input  1  system clock, all state on rising edge
- `RST`  input  1  asynchronous, active-low reset
- `row`  output  32  line counter, 0..V_TOTAL-1 (V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525)
- `col`  output  32  pixel counter, 0..H_TOTAL-1 (H_TOTAL = 800)
- `hsync`  output  1  horizontal sync, active low
- `vsync`  output  1  vertical sync, active low
- `vnotactive`  output  1  high when (`row`,`col`) is outside the visible area
- `pix_tick`  output  1  one-clock strobe, high on the clock whose edge advances `col`
- `frame_start`  output  1  one-clock pulse when the counters become (0,0)
- `frame_cnt`  output  16  frame counter (present only with `VGA_TIMING_FRAME_CNT_EN`)

## Operation
- Divider `div_cnt` counts 0..DIV-1 and wraps. `pix_tick` is high while `div_cnt == DIV-1`. With DIV=1, `pix_tick` is constantly high after reset.
- On each edge with `pix_tick` high, `col` increments. At `col == H_TOTAL-1` it wraps to 0 and `row` increments. At `row == V_TOTAL-1` with `col` wrapping, `row` also wraps to 0.
- Counters keep running through blanking; they are never clamped.
- `hsync` = 0 iff `col` ∈ [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656, 751].
- `vsync` = 0 iff `row` ∈ [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490, 491].
- `vnotactive` = (`col` ≥ H_ACTIVE) or (`row` ≥ V_ACTIVE).
- The sync and blank outputs are registered from the next-state counter values, so they always describe the `row`/`col` shown on the same cycle. They contain no combinational path from the counters.
- `frame_start` is high for exactly one clock: the clock on which `row`/`col` first read (0,0) after a frame wrap. It is not asserted out of reset.
- Width rule: counters are 32 bits, and all compares are unsigned against parameter sums. Parameters must satisfy H_TOTAL, V_TOTAL < 2^31.

## Timing
- Reset values (asynchronous, while `RST`=0):
  - `row`=0, `col`=0, `div_cnt`=0
  - `hsync`=1, `vsync`=1
  - `vnotactive`=0, `pix_tick`=0 (DIV>1) or 1 (DIV=1)
  - `frame_start`=0, `frame_cnt`=0
- After `RST` deasserts, the first `col` increment occurs on the DIV-th rising edge.
- Each (`row`,`col`) value is held for exactly DIV clocks.
- Line period = H_TOTAL·DIV clocks. Frame period = H_TOTAL·V_TOTAL·DIV clocks.
- Reset asserted mid-frame returns all state to reset values immediately. There is no partial-line completion.
- At the simultaneous line and frame wrap, `row`, `col`, `vsync` and `frame_start` all update on the same edge.

## Configuration
- `VGA_TIMING_FRAME_CNT_EN` defined:
  - Port `frame_cnt[15:0]` exists.
  - It increments on the same edge that raises `frame_start` and wraps 65535→0.
  - Reset value is 0.
- Undefined: no `frame_cnt` port and no counter logic. All other behaviour is identical.

## Test plan
- Reset, DIV=2: hold `RST`=0 for 5 clocks → `row`=0, `col`=0, `hsync`=1, `vsync`=1, `vnotactive`=0. Release → `col`=1 after 2 edges, then `col`=2 after 2 more.
- Horizontal sync, DIV=1:
  - `col` 655→656 → `hsync` falls on the same cycle.
  - `col`=752 → `hsync`=1.
  - `col`=640 → `vnotactive`=1.
  - `col`=0 on the next line → `vnotactive`=0.
- Line and frame wrap, DIV=1:
  - (`row`=0, `col`=799) → (1, 0).
  - (524, 799) → (0, 0) with `frame_start`=1 for one clock; `frame_cnt` 0→1 when the macro is defined.
  - Frame period measures 420000 clocks.
- Vertical sync: `vsync`=0 exactly for rows 490–491 (1600 clocks at DIV=1). `vnotactive`=1 for all of rows 480–524.
- Reset mid-frame: assert `RST` at (`row`=300, `col`=400) → outputs return to reset values asynchronously, before the next edge. After release, counting restarts from (0,0) and `frame_start` stays 0 until the first wrap.
- DIV=3: each `col` value is held 3 clocks. `pix_tick` pulses every 3rd clock, aligned with each `col` advance.
